// File: rtl/instr_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory: FSM states,
// the NOP encoding and small sizing helpers.
package instr_mem_loadable_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // NOP is all zeros at any width; replicate this bit to the word width.
  localparam logic NOP_BIT = 1'b0;

  // Default word geometry (32-bit MIPS instructions).
  localparam int DATA_W_DFLT    = 32;
  localparam int BYTES_PER_WORD = DATA_W_DFLT / 8;

  // Bytes per instruction word for an arbitrary width.
  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

  // ceil(log2(n)), never less than 1 so it is usable as a vector width.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/instr_load_assembler.sv
// Byte-stream to word assembler for the program loader. Collects bytes
// MSB-first, emits a write strobe per completed (or final partial) word,
// and flags bytes that arrive after the memory is full.
module instr_load_assembler
  import instr_mem_loadable_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  input  logic              i_last,
  output logic              o_wr_en,
  output logic [IDX_W-1:0]  o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_ovf
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int CNT_W = clog2(BPW);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_W-1:0] r_word;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_ovf;

  logic              w_accept;
  logic              w_full;
  logic              w_word_end;
  logic [DATA_W-1:0] w_word;

  // A restart pulse takes precedence over a byte offered in the same cycle.
  assign w_accept   = i_active & i_valid & ~i_clear;
  assign w_full     = (r_ptr == PTR_W'(DEPTH));
  assign w_word_end = (r_cnt == CNT_W'(BPW - 1)) | i_last;

  // Drop the incoming byte into its slot; untouched low slots stay zero,
  // which gives the zero padding of a final partial word for free.
  always_comb begin
    w_word = r_word;
    for (int b = 0; b < BPW; b++) begin
      if (r_cnt == CNT_W'(b)) w_word[DATA_W-1-8*b -: 8] = i_data;
    end
  end

  assign o_wr_en   = w_accept & w_word_end & ~w_full;
  assign o_wr_addr = r_ptr[IDX_W-1:0];
  assign o_wr_data = w_word;
  assign o_ovf     = r_ovf;

  // Assembler, byte counter, word pointer and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
      r_ptr  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      if (w_word_end) begin
        r_word <= '0;
        r_cnt  <= '0;
        if (!w_full) r_ptr <= r_ptr + PTR_W'(1);
      end else begin
        r_word <= w_word;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_full) r_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// IF-stage instruction memory with a run-time byte-stream loader.
// Registered fetch with stall, flush and out-of-range flagging; a two-state
// FSM gates fetch off while a program is being loaded.
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  input  logic              fetch_en,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_ovf
);

  localparam int IDX_W = clog2(DEPTH);
  localparam logic [DATA_W-1:0] NOP_WORD = {DATA_W{NOP_BIT}};

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  logic              r_done;
  logic [DATA_W-1:0] r_instr_p1;
  logic              r_vld_p1;
  logic              r_err_p1;

  logic              w_in_load;
  logic              w_last_acc;
  logic [IDX_W-1:0]  w_idx;
  logic              w_hi_set;
  logic              w_idx_big;
  logic              w_oor;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_ovf;
  logic              w_unused;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_last_acc = w_in_load & load_valid & load_last & ~load_start;

  // Byte offset within the word is irrelevant to a word-aligned fetch.
  assign w_unused = ^pc[1:0];
  assign w_idx    = pc[IDX_W+1:2];

  if (PC_W > IDX_W + 2) begin : g_hi
    assign w_hi_set = |pc[PC_W-1:IDX_W+2];
  end else begin : g_no_hi
    assign w_hi_set = 1'b0;
  end

  if (DEPTH == (1 << IDX_W)) begin : g_pow2
    assign w_idx_big = 1'b0;
  end else begin : g_npow2
    assign w_idx_big = (w_idx >= IDX_W'(DEPTH));
  end

  assign w_oor     = w_hi_set | w_idx_big;
  assign w_rd_word = w_oor ? NOP_WORD : r_mem[w_idx];

  instr_load_assembler #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (load_start),
    .i_active  (w_in_load),
    .i_valid   (load_valid),
    .i_data    (load_data),
    .i_last    (load_last),
    .o_wr_en   (w_wr_en),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data),
    .o_ovf     (w_ovf)
  );

  // Program store; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  // RUN/LOAD control: load_start (re)enters LOAD, the last byte returns to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last_acc;
      if (load_start)      r_state <= ST_LOAD;
      else if (w_last_acc) r_state <= ST_RUN;
    end
  end

  // Fetch register: flush and loading kill the slot, otherwise capture on fetch_en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_p1 <= NOP_WORD;
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
    end else if (flush || load_start || w_in_load) begin
      r_instr_p1 <= NOP_WORD;
      r_vld_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
    end else if (fetch_en) begin
      r_instr_p1 <= w_rd_word;
      r_vld_p1   <= 1'b1;
      r_err_p1   <= w_oor;
    end
  end

  assign instr       = r_instr_p1;
  assign instr_valid = r_vld_p1;
  assign addr_err    = r_err_p1;
  assign load_ready  = w_in_load;
  assign load_done   = r_done;
  assign load_ovf    = w_ovf;

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised instruction memory for the MIPS pipeline IF stage; replaces the hard-coded program store.
- Program is written at run time through a byte-stream load port.
- Fetch read is registered, with stall (hold) and flush controls and an out-of-range address flag.
- Sits between the PC register and the IF/ID pipeline register; the loader side is driven by the test/boot interface.

Parameters:
- DATA_W, 32, instruction width in bits; must be a multiple of 8.
- DEPTH, 128, number of instruction words stored.
- PC_W, 32, width of the byte-addressed PC input.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  PC_W  byte address of the instruction to fetch.
- fetch_en  in  1  1 = capture a new read; 0 = stall, outputs hold.
- flush  in  1  kill the fetched instruction (branch taken).
- instr  out  DATA_W  registered instruction word.
- instr_valid  out  1  instr holds a real fetch.
- addr_err  out  1  instr came from an out-of-range pc.
- load_start  in  1  single-cycle pulse: begin a program load at word 0.
- load_valid  in  1  load_data byte is offered.
- load_data  in  8  program byte; MSB-first within each word.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  byte accepted when load_valid & load_ready.
- load_done  out  1  one-cycle pulse after the final word is written.
- load_ovf  out  1  sticky: bytes were dropped because DEPTH was exceeded.

Behaviour:
- Reset (async) sets state = RUN, instr = 0, instr_valid = 0, addr_err = 0, load_ready = 0, load_done = 0, load_ovf = 0. Byte and word pointers and the partial-word assembler clear to 0.
- Memory array contents are not reset. Words already written survive reset, including a reset mid-load; the partial word in progress is discarded.
- Word index = pc[log2(DEPTH)+1:2]. pc[1:0] are ignored.
- Out-of-range rule: any pc bit above the index field set, or index >= DEPTH.
- Fetch, RUN state, fetch_en = 1, flush = 0: one cycle later, instr = mem[index], instr_valid = 1, addr_err = 0.
- Fetch out of range: one cycle later, instr = NOP (all zeros), instr_valid = 1, addr_err = 1.
- fetch_en = 0: instr, instr_valid and addr_err hold their values.
- flush = 1 (any state): next cycle instr = 0, instr_valid = 0, addr_err = 0. flush has priority over fetch_en.
- State machine has two states: RUN and LOAD.
  - RUN -> LOAD on load_start. Pointers clear and load_ovf clears.
  - In LOAD: load_ready = 1; instr = 0; instr_valid = 0; fetch_en is ignored.
- Each accepted byte shifts into the assembler (first byte lands in bits DATA_W-1:DATA_W-8).
- When DATA_W/8 bytes are collected: write mem[word_ptr], word_ptr += 1, byte counter returns to 0.
- Byte accepted with load_last = 1:
  - A partial word is zero-padded in its low bytes and written.
  - Next cycle: load_done = 1 for one cycle, state = RUN, load_ready = 0.
- word_ptr == DEPTH: further bytes are still accepted (load_ready stays 1) but not written, and load_ovf is set. load_last still terminates the load normally.
- load_start while in LOAD restarts the load from word 0 and discards the partial word.
- load_start and load_valid in the same cycle: the restart wins and the byte is dropped.
- A memory write and a fetch never coincide, because fetch is disabled in LOAD.

Decomposition:
- Shared package holds:
  - NOP constant (all zeros).
  - state enum {RUN, LOAD}.
  - BYTES_PER_WORD = DATA_W/8.
  - index width function clog2(DEPTH).
- One sub-module, instr_load_assembler: byte shifter, byte counter, word_ptr, overflow flag. Outputs word, write enable and write address.
- The top level holds the memory array, the fetch register and the FSM.

Test Plan:
- Load, fetch: load bytes 80 20 00 0A (load_last on the 4th) -> load_done pulses 1 cycle later; then fetch pc=0 -> next cycle instr=0x8020000A, instr_valid=1, addr_err=0.
- Partial word: load 8 bytes then AB CD with load_last -> mem[2]=0xABCD0000; fetch pc=8 returns 0xABCD0000.
- Out of range: pc=0x200 (DEPTH=128) -> instr=0, instr_valid=1, addr_err=1. Then pc=0x1FC -> mem[127], addr_err=0.
- Stall and flush: fetch pc=0, then fetch_en=0 for 3 cycles with pc changing -> instr holds 0x8020000A. Assert flush together with fetch_en=1 -> instr=0, instr_valid=0.
- Overflow: DEPTH=4, stream 20 bytes -> words 0..3 written, load_ovf=1, load_done still pulses. Then a new load_start -> load_ovf clears.
- Reset mid-load: assert rst after 6 bytes -> state RUN, load_ready=0, instr_valid=0; mem[0] keeps its loaded value and the partial word 1 is not written.
